// File: rtl/ppl_pkg.sv
// ppl_pkg: constants and types shared by the ray-pipeline block-map path.
// Tag encoding identifies the owner of an in-flight RAM read.
package ppl_pkg;

  localparam int PPL_ADDR_W = 15;
  localparam int PPL_DATA_W = 5;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_PPL  = 2'd1;
  localparam logic [1:0] TAG_ED   = 2'd2;
  localparam logic [1:0] TAG_COL  = 2'd3;

  // Which requester owns the RAM slot decided this cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PPL  = 2'd1,
    GNT_ED   = 2'd2,
    GNT_COL  = 2'd3
  } gnt_e;

  // Round-robin preference between the two secondary ports
  typedef enum logic {
    RR_ED  = 1'b0,
    RR_COL = 1'b1
  } rr_e;

  // Return tag for a grant; edit writes produce no read data.
  function automatic logic [1:0] grant_tag(input gnt_e gnt, input logic ed_we);
    logic [1:0] tag;
    case (gnt)
      GNT_PPL: tag = TAG_PPL;
      GNT_ED:  tag = ed_we ? TAG_NONE : TAG_ED;
      GNT_COL: tag = TAG_COL;
      default: tag = TAG_NONE;
    endcase
    return tag;
  endfunction

endpackage

// File: rtl/ppl_blk_tagpipe.sv
// ppl_blk_tagpipe: RD_LAT+1 stage tag shift register that follows each RAM
// read to the cycle its data appears, then registers the data into the
// owning port. Non-owner rdata holds its last value.
module ppl_blk_tagpipe
  import ppl_pkg::*;
#(
  parameter int DATA_W = PPL_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        tag_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              ppl_rvalid_o,
  output logic [DATA_W-1:0] ppl_rdata_o,
  output logic              ed_rvalid_o,
  output logic [DATA_W-1:0] ed_rdata_o,
  output logic              col_rvalid_o,
  output logic [DATA_W-1:0] col_rdata_o
);

  // Stage 0 is loaded on the same edge as ram_en; stage RD_LAT lines up
  // with valid ram_rdata.
  logic [RD_LAT:0][1:0] tag_q;
  logic [1:0]           ret_tag_s;

  logic                 ppl_rvalid_q, ppl_rvalid_d;
  logic                 ed_rvalid_q, ed_rvalid_d;
  logic                 col_rvalid_q, col_rvalid_d;
  logic [DATA_W-1:0]    ppl_rdata_q, ppl_rdata_d;
  logic [DATA_W-1:0]    ed_rdata_q, ed_rdata_d;
  logic [DATA_W-1:0]    col_rdata_q, col_rdata_d;

  assign ret_tag_s = tag_q[RD_LAT];

  // Shift tags toward the return stage; reset discards everything in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q <= '0;
    end else begin
      tag_q <= {tag_q[RD_LAT-1:0], tag_i};
    end
  end

  // Demux returning RAM data to the owner named by the oldest tag
  always_comb begin
    ppl_rvalid_d = 1'b0;
    ed_rvalid_d  = 1'b0;
    col_rvalid_d = 1'b0;
    ppl_rdata_d  = ppl_rdata_q;
    ed_rdata_d   = ed_rdata_q;
    col_rdata_d  = col_rdata_q;
    case (ret_tag_s)
      TAG_PPL: begin
        ppl_rvalid_d = 1'b1;
        ppl_rdata_d  = rdata_i;
      end
      TAG_ED: begin
        ed_rvalid_d = 1'b1;
        ed_rdata_d  = rdata_i;
      end
      TAG_COL: begin
        col_rvalid_d = 1'b1;
        col_rdata_d  = rdata_i;
      end
      default: begin
        ppl_rvalid_d = 1'b0;
        ed_rvalid_d  = 1'b0;
        col_rvalid_d = 1'b0;
      end
    endcase
  end

  // Register the per-port return data and valid strobes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ppl_rvalid_q <= 1'b0;
      ed_rvalid_q  <= 1'b0;
      col_rvalid_q <= 1'b0;
      ppl_rdata_q  <= '0;
      ed_rdata_q   <= '0;
      col_rdata_q  <= '0;
    end else begin
      ppl_rvalid_q <= ppl_rvalid_d;
      ed_rvalid_q  <= ed_rvalid_d;
      col_rvalid_q <= col_rvalid_d;
      ppl_rdata_q  <= ppl_rdata_d;
      ed_rdata_q   <= ed_rdata_d;
      col_rdata_q  <= col_rdata_d;
    end
  end

  assign ppl_rvalid_o = ppl_rvalid_q;
  assign ppl_rdata_o  = ppl_rdata_q;
  assign ed_rvalid_o  = ed_rvalid_q;
  assign ed_rdata_o   = ed_rdata_q;
  assign col_rvalid_o = col_rvalid_q;
  assign col_rdata_o  = col_rdata_q;

endmodule

// File: rtl/ppl_blk_arb.sv
// ppl_blk_arb: single-port block-map RAM arbiter. The ray pipeline always
// wins; edit and collision ports share idle slots round-robin. Reads return
// on a fixed RD_LAT+2 cycle tagged path.
// Optional build macro PPL_BLK_ARB_WRITE_LOCK_EN: edit writes are held off
// while frame_busy=1 (reads unaffected); otherwise frame_busy is ignored.
module ppl_blk_arb
  import ppl_pkg::*;
#(
  parameter int ADDR_W     = PPL_ADDR_W,
  parameter int DATA_W     = PPL_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 64
) (
  input  logic              clk_ppl,
  input  logic              rst,
  input  logic              ppl_req,
  input  logic [ADDR_W-1:0] ppl_addr,
  output logic              ppl_rvalid,
  output logic [DATA_W-1:0] ppl_rdata,
  input  logic              ed_req,
  input  logic              ed_we,
  input  logic [ADDR_W-1:0] ed_addr,
  input  logic [DATA_W-1:0] ed_wdata,
  output logic              ed_ack,
  output logic              ed_rvalid,
  output logic [DATA_W-1:0] ed_rdata,
  input  logic              col_req,
  input  logic [ADDR_W-1:0] col_addr,
  output logic              col_ack,
  output logic              col_rvalid,
  output logic [DATA_W-1:0] col_rdata,
  input  logic              frame_busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              starve_flag
);

  localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic              ed_lock_s;
  logic              ed_elig_s;
  logic              col_elig_s;
  gnt_e              gnt_s;
  logic [1:0]        tag_d;

  rr_e               rr_q, rr_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              starve_q, starve_d;

  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ed_ack_q, ed_ack_d;
  logic              col_ack_q, col_ack_d;

`ifdef PPL_BLK_ARB_WRITE_LOCK_EN
  // No edit writes land while a frame is being rendered
  assign ed_lock_s = ed_we & frame_busy;
`else
  logic frame_busy_unused;
  assign frame_busy_unused = frame_busy;
  assign ed_lock_s         = 1'b0;
`endif

  // A port whose ack is high this cycle is still holding the request it was
  // just granted, so it must not be issued a second time.
  assign ed_elig_s  = ed_req & ~ed_ack_q & ~ed_lock_s;
  assign col_elig_s = col_req & ~col_ack_q;

  // Grant decision: pipeline first, then round-robin between edit and probe
  always_comb begin
    gnt_s = GNT_NONE;
    rr_d  = rr_q;
    if (ppl_req) begin
      gnt_s = GNT_PPL;
    end else if (ed_elig_s && col_elig_s) begin
      if (rr_q == RR_ED) begin
        gnt_s = GNT_ED;
        rr_d  = RR_COL;
      end else begin
        gnt_s = GNT_COL;
        rr_d  = RR_ED;
      end
    end else if (ed_elig_s) begin
      gnt_s = GNT_ED;
    end else if (col_elig_s) begin
      gnt_s = GNT_COL;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  // Starvation: count pipeline-blocked cycles with a secondary waiting,
  // cleared once a secondary request actually issues
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (ed_ack_q || col_ack_q) begin
      starve_cnt_d = '0;
    end else if (ppl_req && (ed_elig_s || col_elig_s) && (starve_cnt_q < STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + CNT_ONE;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
    starve_d = (starve_cnt_d == STARVE_LIM);
  end

  // Next-cycle RAM command, acks and return tag for the granted port
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    ed_ack_d    = 1'b0;
    col_ack_d   = 1'b0;
    case (gnt_s)
      GNT_PPL: begin
        ram_en_d   = 1'b1;
        ram_addr_d = ppl_addr;
      end
      GNT_ED: begin
        ram_en_d    = 1'b1;
        ram_we_d    = ed_we;
        ram_addr_d  = ed_addr;
        ram_wdata_d = ed_we ? ed_wdata : '0;
        ed_ack_d    = 1'b1;
      end
      GNT_COL: begin
        ram_en_d   = 1'b1;
        ram_addr_d = col_addr;
        col_ack_d  = 1'b1;
      end
      default: begin
        ram_en_d = 1'b0;
      end
    endcase
    tag_d = grant_tag(gnt_s, ed_we);
  end

  // Arbiter state and registered outputs
  always_ff @(posedge clk_ppl) begin
    if (rst) begin
      rr_q         <= RR_ED;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ed_ack_q     <= 1'b0;
      col_ack_q    <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ed_ack_q     <= ed_ack_d;
      col_ack_q    <= col_ack_d;
    end
  end

  ppl_blk_tagpipe #(
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_tagpipe (
    .clk_i       (clk_ppl),
    .rst_i       (rst),
    .tag_i       (tag_d),
    .rdata_i     (ram_rdata),
    .ppl_rvalid_o(ppl_rvalid),
    .ppl_rdata_o (ppl_rdata),
    .ed_rvalid_o (ed_rvalid),
    .ed_rdata_o  (ed_rdata),
    .col_rvalid_o(col_rvalid),
    .col_rdata_o (col_rdata)
  );

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ed_ack      = ed_ack_q;
  assign col_ack     = col_ack_q;
  assign starve_flag = starve_q;

endmodule

// File: tb/tb_ppl_blk_arb.sv
// tb_ppl_blk_arb: directed stimulus against ppl_blk_arb with a transaction
// level model (grant order, memory image, return queue) checked every cycle,
// plus hand-computed literal expectations for latency, data and ordering.
module tb_ppl_blk_arb;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 5;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 64;
`ifdef PPL_BLK_ARB_WRITE_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic              clk_ppl = 1'b0;
  logic              rst = 1'b1;
  logic              ppl_req = 1'b0;
  logic [ADDR_W-1:0] ppl_addr = '0;
  logic              ppl_rvalid;
  logic [DATA_W-1:0] ppl_rdata;
  logic              ed_req = 1'b0;
  logic              ed_we = 1'b0;
  logic [ADDR_W-1:0] ed_addr = '0;
  logic [DATA_W-1:0] ed_wdata = '0;
  logic              ed_ack, ed_rvalid;
  logic [DATA_W-1:0] ed_rdata;
  logic              col_req = 1'b0;
  logic [ADDR_W-1:0] col_addr = '0;
  logic              col_ack, col_rvalid;
  logic [DATA_W-1:0] col_rdata;
  logic              frame_busy = 1'b0;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              starve_flag;

  always #5 clk_ppl = ~clk_ppl;

  ppl_blk_arb dut (
    .clk_ppl(clk_ppl), .rst(rst),
    .ppl_req(ppl_req), .ppl_addr(ppl_addr), .ppl_rvalid(ppl_rvalid), .ppl_rdata(ppl_rdata),
    .ed_req(ed_req), .ed_we(ed_we), .ed_addr(ed_addr), .ed_wdata(ed_wdata),
    .ed_ack(ed_ack), .ed_rvalid(ed_rvalid), .ed_rdata(ed_rdata),
    .col_req(col_req), .col_addr(col_addr), .col_ack(col_ack),
    .col_rvalid(col_rvalid), .col_rdata(col_rdata),
    .frame_busy(frame_busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .starve_flag(starve_flag)
  );

  // Single-port RAM, 1-cycle read latency, preloaded with addr[4:0]
  logic [DATA_W-1:0] mem [0:32767];
  bit ram_init_done = 1'b0;
  always @(posedge clk_ppl) begin
    if (!ram_init_done) begin
      for (int a = 0; a < 32768; a++) mem[a] <= 5'(a);
      ram_init_done <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
    end
  end

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct { int due; int owner; logic [DATA_W-1:0] data; } ret_t;
  ret_t ret_q[$];
  logic [DATA_W-1:0] mem_m [0:32767];
  bit pref_ed = 1'b1;
  int stv = 0;
  logic              e_ram_en = 0, e_ram_we = 0, e_ed_ack = 0, e_col_ack = 0, e_starve = 0;
  logic [ADDR_W-1:0] e_ram_addr = '0;
  logic [DATA_W-1:0] e_ram_wdata = '0;
  logic              e_ppl_rv = 0, e_ed_rv = 0, e_col_rv = 0;
  logic [DATA_W-1:0] e_ppl_rd = '0, e_ed_rd = '0, e_col_rd = '0;

  always @(posedge clk_ppl) begin
    bit el_ed, el_col, g_ed, g_col;
    ret_t r;
    if (rst) begin
      pref_ed = 1'b1; stv = 0; ret_q.delete();
      e_ram_en = 0; e_ram_we = 0; e_ram_addr = '0; e_ram_wdata = '0;
      e_ed_ack = 0; e_col_ack = 0; e_starve = 0;
      e_ppl_rd = '0; e_ed_rd = '0; e_col_rd = '0;
    end else begin
      el_ed  = ed_req && !e_ed_ack && !(LOCK_ON && ed_we && frame_busy);
      el_col = col_req && !e_col_ack;
      g_ed = 0; g_col = 0;
      if (!ppl_req) begin
        if (el_ed && el_col) begin
          if (pref_ed) g_ed = 1; else g_col = 1;
          pref_ed = !pref_ed;
        end else if (el_ed) g_ed = 1;
        else if (el_col) g_col = 1;
      end
      if (e_ed_ack || e_col_ack) stv = 0;
      else if (ppl_req && (el_ed || el_col) && stv < STARVE_MAX) stv = stv + 1;
      e_starve    = (stv >= STARVE_MAX);
      e_ed_ack    = g_ed;
      e_col_ack   = g_col;
      e_ram_en    = ppl_req || g_ed || g_col;
      e_ram_we    = g_ed && ed_we;
      e_ram_wdata = (g_ed && ed_we) ? ed_wdata : '0;
      e_ram_addr  = ppl_req ? ppl_addr : (g_ed ? ed_addr : (g_col ? col_addr : '0));
      if (ppl_req) ret_q.push_back('{cyc + RD_LAT + 2, 1, mem_m[ppl_addr]});
      else if (g_ed && ed_we) mem_m[ed_addr] = ed_wdata;
      else if (g_ed) ret_q.push_back('{cyc + RD_LAT + 2, 2, mem_m[ed_addr]});
      else if (g_col) ret_q.push_back('{cyc + RD_LAT + 2, 3, mem_m[col_addr]});
    end
    cyc++;
    e_ppl_rv = 0; e_ed_rv = 0; e_col_rv = 0;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      r = ret_q.pop_front();
      case (r.owner)
        1: begin e_ppl_rv = 1; e_ppl_rd = r.data; end
        2: begin e_ed_rv = 1; e_ed_rd = r.data; end
        default: begin e_col_rv = 1; e_col_rd = r.data; end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk_ppl) begin
    if (chk_en) begin
      chk("ram_en",      32'(ram_en),      32'(e_ram_en));
      chk("ram_we",      32'(ram_we),      32'(e_ram_we));
      chk("ram_addr",    32'(ram_addr),    32'(e_ram_addr));
      chk("ram_wdata",   32'(ram_wdata),   32'(e_ram_wdata));
      chk("ed_ack",      32'(ed_ack),      32'(e_ed_ack));
      chk("col_ack",     32'(col_ack),     32'(e_col_ack));
      chk("starve_flag", 32'(starve_flag), 32'(e_starve));
      chk("ppl_rvalid",  32'(ppl_rvalid),  32'(e_ppl_rv));
      chk("ppl_rdata",   32'(ppl_rdata),   32'(e_ppl_rd));
      chk("ed_rvalid",   32'(ed_rvalid),   32'(e_ed_rv));
      chk("ed_rdata",    32'(ed_rdata),    32'(e_ed_rd));
      chk("col_rvalid",  32'(col_rvalid),  32'(e_col_rv));
      chk("col_rdata",   32'(col_rdata),   32'(e_col_rd));
    end
  end

  // Pipeline return collector for the streaming test
  bit t1_on = 1'b0;
  int t1_first = -1;
  logic [DATA_W-1:0] t1_got[$];
  always @(negedge clk_ppl) begin
    if (t1_on && ppl_rvalid) begin
      if (t1_first < 0) t1_first = cyc;
      t1_got.push_back(ppl_rdata);
    end
  end

  task automatic wait_ed_ack(output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_ppl);
      if (ed_ack) begin at = cyc; break; end
    end
    chk("ed_ack_wait", 32'(at >= 0), 32'd1);
  endtask

  task automatic col_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp_d);
    int m, ack_at, rv_at;
    col_req = 1'b1; col_addr = a; m = cyc; ack_at = -1; rv_at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_ppl);
      if (col_ack) begin ack_at = cyc; break; end
    end
    col_req = 1'b0;
    chk("col_ack_wait", 32'(ack_at >= 0), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_ppl);
      if (col_rvalid) begin rv_at = cyc; break; end
    end
    chk("col_read_latency", 32'(rv_at - m), 32'd3);
    chk("col_read_data", 32'(col_rdata), 32'(exp_d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, at, rise, cnt, ed_in_ppl, f;
    logic [4:0] want;
    for (int a = 0; a < 32768; a++) mem_m[a] = 5'(a);

    // Reset: all outputs zero
    repeat (3) @(negedge clk_ppl);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_acks", 32'({ed_ack, col_ack}), 32'd0);
    chk("rst_rvalids", 32'({ppl_rvalid, ed_rvalid, col_rvalid}), 32'd0);
    chk("rst_starve", 32'(starve_flag), 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Pipeline streams addresses 0..99 while an edit read waits
    t1_on = 1'b1; ed_in_ppl = 0;
    ed_req = 1'b1; ed_we = 1'b0; ed_addr = 15'd5;
    s = cyc;
    for (int i = 0; i < 100; i++) begin
      ppl_req = 1'b1; ppl_addr = 15'(i);
      @(negedge clk_ppl);
      if (ed_ack) ed_in_ppl++;
    end
    ppl_req = 1'b0;
    wait_ed_ack(at);
    ed_req = 1'b0;
    repeat (6) @(negedge clk_ppl);
    t1_on = 1'b0;
    chk("ppl_first_latency", 32'(t1_first - s), 32'd3);
    chk("ppl_rvalid_count", 32'(t1_got.size()), 32'd100);
    chk("ed_ack_during_ppl", 32'(ed_in_ppl), 32'd0);
    for (int i = 0; i < 100 && i < t1_got.size(); i++) begin
      want = i[4:0];
      chk("ppl_stream_data", 32'(t1_got[i]), 32'(want));
    end

    // Edit write 0x1234 <= 7, then collision read of the same address
    ed_req = 1'b1; ed_we = 1'b1; ed_addr = 15'h1234; ed_wdata = 5'd7;
    wait_ed_ack(at);
    chk("wr_ram_we", 32'(ram_we), 32'd1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h1234);
    chk("wr_ram_wdata", 32'(ram_wdata), 32'd7);
    ed_req = 1'b0; ed_we = 1'b0;
    @(negedge clk_ppl);
    chk("ed_ack_pulse", 32'(ed_ack), 32'd0);
    col_read(15'h1234, 5'd7);

    // Both secondaries held: acks alternate ED, COL, ...
    @(negedge clk_ppl);
    ed_req = 1'b1; ed_we = 1'b0; ed_addr = 15'd3;
    col_req = 1'b1; col_addr = 15'd9;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_ppl);
      chk("rr_ack_order", 32'({ed_ack, col_ack}), (k % 2 == 0) ? 32'd2 : 32'd1);
    end
    ed_req = 1'b0; col_req = 1'b0;
    repeat (5) @(negedge clk_ppl);

    // Starvation: pipeline busy 80 cycles with a collision probe pending
    col_req = 1'b1; col_addr = 15'h0010;
    s = cyc; rise = -1; cnt = 0;
    for (int i = 0; i < 80; i++) begin
      ppl_req = 1'b1; ppl_addr = 15'(200 + i);
      @(negedge clk_ppl);
      if (starve_flag && rise < 0) rise = cyc;
      if (col_ack) cnt++;
    end
    ppl_req = 1'b0;
    chk("starve_rise_cycle", 32'(rise - s), 32'd64);
    chk("col_ack_while_ppl", 32'(cnt), 32'd0);
    @(negedge clk_ppl);
    chk("starve_col_ack", 32'(col_ack), 32'd1);
    chk("starve_held_at_ack", 32'(starve_flag), 32'd1);
    col_req = 1'b0;
    @(negedge clk_ppl);
    chk("starve_cleared", 32'(starve_flag), 32'd0);
    repeat (4) @(negedge clk_ppl);

    // Reset with two pipeline reads in flight
    ppl_req = 1'b1; ppl_addr = 15'd20;
    @(negedge clk_ppl);
    ppl_addr = 15'd21;
    @(negedge clk_ppl);
    ppl_req = 1'b0; rst = 1'b1;
    @(negedge clk_ppl);
    rst = 1'b0;
    chk("post_rst_ram_en", 32'(ram_en), 32'd0);
    chk("post_rst_rvalid", 32'({ppl_rvalid, ed_rvalid, col_rvalid}), 32'd0);
    chk("post_rst_rdata", 32'({ppl_rdata, ed_rdata, col_rdata}), 32'd0);
    chk("post_rst_flags", 32'({ed_ack, col_ack, starve_flag, ram_we}), 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_ppl);
      if (ppl_rvalid || ed_rvalid || col_rvalid) cnt++;
    end
    chk("no_rvalid_after_rst", 32'(cnt), 32'd0);

    // Edit write during a frame
    frame_busy = 1'b1;
    ed_req = 1'b1; ed_we = 1'b1; ed_addr = 15'h0042; ed_wdata = 5'd19;
`ifdef PPL_BLK_ARB_WRITE_LOCK_EN
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_ppl);
      chk("locked_no_ack", 32'(ed_ack), 32'd0);
    end
    frame_busy = 1'b0;
    f = cyc;
    wait_ed_ack(at);
    chk("lock_release_ack", 32'((at - f) <= 2), 32'd1);
`else
    f = cyc;
    @(negedge clk_ppl);
    chk("unlocked_first_slot_ack", 32'(ed_ack), 32'd1);
`endif
    ed_req = 1'b0; ed_we = 1'b0; frame_busy = 1'b0;
    @(negedge clk_ppl);
    col_read(15'h0042, 5'd19);

    repeat (5) @(negedge clk_ppl);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
